// File: rtl/sd_sector_writer.sv
// CPU-to-SD sector write path: CPU fills a 512-byte buffer, a start strobe raises sd_wr
// toward hps_io, and the buffer is served to the HPS during the sd_ack window.
module sd_sector_writer #(
  parameter int unsigned       TO_W    = 24,
  parameter logic [TO_W-1:0]   TIMEOUT = 24'd12000000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [8:0]  cpu_buf_addr,
  input  logic [7:0]  cpu_buf_data,
  input  logic        cpu_buf_we,
  output logic [7:0]  cpu_buf_q,
  input  logic [31:0] lba_in,
  input  logic        start,
  input  logic        img_present,
  input  logic        img_readonly,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] sd_lba,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  output logic [7:0]  sd_buff_din
);

  localparam logic [TO_W-1:0] LastCount = TIMEOUT - TO_W'(1);

  typedef enum logic [1:0] {StIdle, StReq, StXfer} state_e;

  state_e            state_q, state_d;
  logic              sd_wr_q, sd_wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       lba_q, lba_d;
  logic [TO_W-1:0]   count_q, count_d;

  logic [7:0] mem [512];

  // Buffer is not reset; CPU writes only land while no transfer is in flight.
  always_ff @(posedge clk_sys) begin
    if (cpu_buf_we && (state_q == StIdle)) begin
      mem[cpu_buf_addr] <= cpu_buf_data;
    end
    cpu_buf_q   <= mem[cpu_buf_addr];
    sd_buff_din <= mem[sd_buff_addr];
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      sd_wr_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      lba_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sd_wr_q <= sd_wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      lba_q   <= lba_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sd_wr_d = sd_wr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    lba_d   = lba_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (img_readonly || !img_present) begin
            err_d = 1'b1;
          end else begin
            lba_d   = lba_in;
            sd_wr_d = 1'b1;
            busy_d  = 1'b1;
            err_d   = 1'b0;
            count_d = '0;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        // Ack wins over a timeout expiring on the same cycle.
        if (sd_ack) begin
          sd_wr_d = 1'b0;
          state_d = StXfer;
        end else if (count_q == LastCount) begin
          sd_wr_d = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          count_d = count_q + TO_W'(1);
        end
      end
      StXfer: begin
        if (!sd_ack) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign sd_wr  = sd_wr_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign sd_lba = lba_q;

endmodule
